// File: rtl/spi_cmd_pkg.sv
// Shared types and command-frame field map for the SPI command receiver.
// Field offsets assume the 51-byte command frame layout.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    CHECK
  } spi_rx_state_t;

  localparam int TIME_W = 64;

  localparam int FLD_TIME_HI         = 407;
  localparam int FLD_TIME_LO         = 344;
  localparam int FLD_FREQ_HI         = 343;
  localparam int FLD_FREQ_LO         = 296;
  localparam int FLD_FREQ_STEP_HI    = 295;
  localparam int FLD_FREQ_STEP_LO    = 248;
  localparam int FLD_FREQ_RATE_HI    = 247;
  localparam int FLD_FREQ_RATE_LO    = 216;
  localparam int FLD_TIME_START_HI   = 215;
  localparam int FLD_TIME_START_LO   = 152;
  localparam int FLD_N_IMPULSE_HI    = 151;
  localparam int FLD_N_IMPULSE_LO    = 136;
  localparam int FLD_TYPE_IMPULSE_HI = 135;
  localparam int FLD_TYPE_IMPULSE_LO = 128;
  localparam int FLD_INTERVAL_TI_HI  = 127;
  localparam int FLD_INTERVAL_TI_LO  = 96;
  localparam int FLD_INTERVAL_TP_HI  = 95;
  localparam int FLD_INTERVAL_TP_LO  = 64;
  localparam int FLD_TBLANK1_HI      = 63;
  localparam int FLD_TBLANK1_LO      = 32;
  localparam int FLD_TBLANK2_HI      = 31;
  localparam int FLD_TBLANK2_LO      = 0;

endpackage

// File: rtl/spi_cmd_rx_sync_edge.sv
// Synchroniser for an asynchronous pin with registered rise/fall strobes.
// RST_VAL sets what the chain looks like out of reset, so no false edge.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Shift the pin through the chain and compare the last two samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
      rise   <= sync_r[STAGES-1] & ~prev_r;
      fall   <= ~sync_r[STAGES-1] & prev_r;
    end
  end

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI-slave command-frame receiver, oversampled in the clk domain.
// Emits whole frames of FRAME_BYTES bytes and a stretched time flag.
module spi_cmd_rx
  import spi_cmd_pkg::*;
#(
  parameter int FRAME_BYTES = 51,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter int TIME_HOLD   = 128
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sclk,
  input  logic                                 cs_n,
  input  logic                                 mosi,
  output logic [FRAME_BYTES*8-1:0]             frame_data,
  output logic                                 frame_wr,
  output logic                                 frame_err,
  output logic                                 time_update,
  output logic [$clog2(FRAME_BYTES*8+2)-1:0]   bit_cnt
);

  localparam int FRAME_W = FRAME_BYTES * 8;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int HOLD_W  = $clog2(TIME_HOLD + 2);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_OVF   = CNT_W'(FRAME_W + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(TIME_HOLD);

  // Modes 0 and 3 sample on the rising SCLK edge, 1 and 2 on falling.
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic sclk_smp;

  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_d;

  spi_rx_state_t        state;
  logic [FRAME_W-1:0]   shift_r;
  logic [HOLD_W-1:0]    hold_cnt;

  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (CPOL)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Chain resets low so cs_n held low across reset never looks
  // like a fresh falling edge.
  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign sclk_smp = SAMPLE_RISE ? sclk_rise : sclk_fall;

  // mosi_d lines up with the sample that produced the SCLK strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync <= '0;
      mosi_d    <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // Frame FSM: collect bits under cs_n, then judge the bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_r    <= '0;
      bit_cnt    <= '0;
      frame_data <= '0;
      frame_wr   <= 1'b0;
      frame_err  <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      frame_wr  <= 1'b0;
      frame_err <= 1'b0;
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= RX;
            shift_r <= '0;
            bit_cnt <= '0;
          end
        end
        RX: begin
          if (sclk_smp && bit_cnt != CNT_OVF) begin
            shift_r <= {shift_r[FRAME_W-2:0], mosi_d};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (cs_rise) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (bit_cnt == CNT_FULL) begin
            frame_data <= shift_r;
            frame_wr   <= 1'b1;
            if (|shift_r[FRAME_W-1 -: TIME_W]) begin
              hold_cnt <= HOLD_LOAD;
            end
          end else if (bit_cnt != '0) begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign time_update = (hold_cnt != '0);

endmodule
